// File: rtl/eBike_pkg.sv
// Shared widths and helpers for the eBike rider-effort conditioning path.
package eBike_pkg;

    localparam int unsigned TORQUE_W    = 12;
    localparam int unsigned CADENCE_W   = 5;
    localparam int unsigned CADENCE_MAX = 31;

    typedef logic [TORQUE_W-1:0]  torque_t;
    typedef logic [CADENCE_W-1:0] cadence_t;

    function automatic cadence_t cadence_sat_inc(input cadence_t v);
        return (v == CADENCE_W'(CADENCE_MAX)) ? v : v + CADENCE_W'(1);
    endfunction

endpackage

// File: rtl/cadence_filt.sv
// Cadence magnet conditioning: two-flop synchronizer, persistence deglitch filter
// and single-cycle rising-edge detector on the filtered level.
module cadence_filt #(
    parameter int unsigned FILT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic cadence_raw,
    output logic cad_filt,
    output logic cad_rise
);

    localparam int unsigned CntW = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;

    logic            sync1_q, sync1_d;
    logic            sync2_q, sync2_d;
    logic            filt_q, filt_d;
    logic            filt_prev_q, filt_prev_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d     = cadence_raw;
        sync2_d     = sync1_q;
        filt_d      = filt_q;
        filt_prev_d = filt_q;
        cnt_d       = cnt_q;
        // The filtered level only moves once the synced level has disagreed
        // with it for FILT_CYCLES consecutive cycles.
        if (sync2_q == filt_q) begin
            cnt_d = '0;
        end else if (cnt_q == CntW'(FILT_CYCLES - 1)) begin
            filt_d = sync2_q;
            cnt_d  = '0;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            filt_q      <= 1'b0;
            filt_prev_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            filt_q      <= filt_d;
            filt_prev_q <= filt_prev_d;
            cnt_q       <= cnt_d;
        end
    end

    assign cad_filt = filt_q;
    assign cad_rise = filt_q & ~filt_prev_q;

endmodule

// File: rtl/pedal_sensor_cond.sv
// Pedal sensor conditioning: strokes per fixed window (cadence / not_pedaling) and a
// per-stroke exponential average of the latched torque sample.
module pedal_sensor_cond
    import eBike_pkg::*;
#(
    parameter int unsigned FILT_CYCLES    = 1024,
    parameter int unsigned WIN_CYCLES     = 16777216,
    parameter int unsigned NOT_PED_THRESH = 2,
    parameter int unsigned AVG_SHIFT      = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cadence_raw,
    input  logic [TORQUE_W-1:0]  torque,
    input  logic                 torque_vld,
    output logic [TORQUE_W-1:0]  avg_torque,
    output logic [CADENCE_W-1:0] cadence,
    output logic                 not_pedaling
);

    localparam int unsigned AccW = TORQUE_W + AVG_SHIFT;
    localparam int unsigned WinW = (WIN_CYCLES > 1) ? $clog2(WIN_CYCLES) : 1;

    logic cad_filt;
    logic cad_rise;
    logic stroke;

    cadence_filt #(
        .FILT_CYCLES (FILT_CYCLES)
    ) u_cadence_filt (
        .clk         (clk),
        .rst         (rst),
        .cadence_raw (cadence_raw),
        .cad_filt    (cad_filt),
        .cad_rise    (cad_rise)
    );

    // A rise always coincides with a high filtered level; qualifying keeps both taps live.
    assign stroke = cad_rise & cad_filt;

    logic [WinW-1:0] win_q, win_d;
    cadence_t        stroke_cnt_q, stroke_cnt_d;
    cadence_t        cadence_q, cadence_d;
    logic            not_ped_q, not_ped_d;
    torque_t         torque_lat_q, torque_lat_d;
    logic [AccW-1:0] acc_q, acc_d;
    logic            tc;
    cadence_t        stroke_cnt_inc;

    assign tc = (win_q == WinW'(WIN_CYCLES - 1));

    always_comb begin
        win_d          = tc ? '0 : win_q + WinW'(1);
        stroke_cnt_inc = stroke ? cadence_sat_inc(stroke_cnt_q) : stroke_cnt_q;
        stroke_cnt_d   = stroke_cnt_inc;
        cadence_d      = cadence_q;
        not_ped_d      = not_ped_q;
        if (tc) begin
            cadence_d    = stroke_cnt_inc;
            not_ped_d    = (32'(stroke_cnt_inc) < NOT_PED_THRESH);
            stroke_cnt_d = '0;
        end
    end

    always_comb begin
        torque_lat_d = torque_vld ? torque : torque_lat_q;
        acc_d        = acc_q;
        // Uses the pre-update latch, so a sample arriving with the stroke waits a stroke.
        if (stroke) begin
            acc_d = acc_q - (acc_q >> AVG_SHIFT) + AccW'(torque_lat_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            win_q        <= '0;
            stroke_cnt_q <= '0;
            cadence_q    <= '0;
            not_ped_q    <= 1'b1;
            torque_lat_q <= '0;
            acc_q        <= '0;
        end else begin
            win_q        <= win_d;
            stroke_cnt_q <= stroke_cnt_d;
            cadence_q    <= cadence_d;
            not_ped_q    <= not_ped_d;
            torque_lat_q <= torque_lat_d;
            acc_q        <= acc_d;
        end
    end

    assign avg_torque   = acc_q[AccW-1:AVG_SHIFT];
    assign cadence      = cadence_q;
    assign not_pedaling = not_ped_q;

endmodule

// File: tb/tb_pedal_sensor_cond.sv
// Self-checking bench for pedal_sensor_cond against a cycle-indexed behavioural model.
module tb_pedal_sensor_cond;

    localparam int FILT = 4;
    localparam int WIN  = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cadence_raw = 1'b0;
    logic [11:0] torque = '0;
    logic        torque_vld = 1'b0;
    logic [11:0] avg_torque;
    logic [4:0]  cadence;
    logic        not_pedaling;

    pedal_sensor_cond #(
        .FILT_CYCLES    (FILT),
        .WIN_CYCLES     (WIN),
        .NOT_PED_THRESH (2),
        .AVG_SHIFT      (5)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cadence_raw  (cadence_raw),
        .torque       (torque),
        .torque_vld   (torque_vld),
        .avg_torque   (avg_torque),
        .cadence      (cadence),
        .not_pedaling (not_pedaling)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit exp_rise[int];
    int m_acc = 0, m_lat = 0, m_strokes = 0, m_cad = 0, m_notped = 1;

    // Model: a clean pulse starting in cycle r strokes in cycle r+2+FILT; cycle n of
    // the window is n mod WIN after reset release; stroke on the last cycle counts.
    task automatic tick();
        if (rst) begin
            m_acc = 0; m_lat = 0; m_strokes = 0; m_cad = 0; m_notped = 1;
            exp_rise.delete();
        end else begin
            if (exp_rise.exists(cyc)) begin
                m_acc = m_acc - m_acc / 32 + m_lat;
                if (m_strokes < 31) m_strokes++;
            end
            if (torque_vld) m_lat = torque;
            if (cyc % WIN == WIN - 1) begin
                m_cad     = m_strokes;
                m_notped  = (m_strokes < 2) ? 1 : 0;
                m_strokes = 0;
            end
        end
        @(posedge clk);
        #1;
        cyc = rst ? 0 : cyc + 1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic stroke(input int hi, input int lo, input int vld_off = -1,
                          input int vld_val = 0);
        cadence_raw = 1'b1;
        if (hi >= FILT) exp_rise[cyc + 2 + FILT] = 1'b1;
        for (int k = 0; k < hi + lo; k++) begin
            if (k == hi) cadence_raw = 1'b0;
            if (k == vld_off) begin
                torque     = 12'(vld_val);
                torque_vld = 1'b1;
            end
            tick();
            torque_vld = 1'b0;
        end
    endtask

    task automatic to_window_end();
        do tick(); while (cyc % WIN != 0);
    endtask

    task automatic load_torque(input int v);
        torque     = 12'(v);
        torque_vld = 1'b1;
        tick();
        torque_vld = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        checks++;
        if (avg_torque !== 12'h000) begin
            errors++; $display("FAIL reset_avg: got %h expected 000", avg_torque);
        end
        checks++;
        if (cadence !== 5'd0 || not_pedaling !== 1'b1) begin
            errors++;
            $display("FAIL reset_cad: got cad=%0d np=%b expected cad=0 np=1", cadence, not_pedaling);
        end
        to_window_end();
        checks++;
        if (avg_torque !== 12'h000 || cadence !== 5'd0 || not_pedaling !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_tc: got avg=%h cad=%0d np=%b expected 000/0/1",
                     avg_torque, cadence, not_pedaling);
        end
    endtask

    task automatic test_glitch();
        stroke(3, 20);
        to_window_end();
        checks++;
        if (cadence !== 5'd0 || not_pedaling !== 1'b1) begin
            errors++;
            $display("FAIL glitch: got cad=%0d np=%b expected cad=0 np=1", cadence, not_pedaling);
        end
    endtask

    task automatic test_clean();
        for (int i = 0; i < 10; i++) stroke(8, 8);
        to_window_end();
        checks++;
        if (cadence !== 5'd10 || not_pedaling !== 1'b0) begin
            errors++;
            $display("FAIL clean_10: got cad=%0d np=%b expected cad=10 np=0", cadence, not_pedaling);
        end
        to_window_end();
        checks++;
        if (cadence !== 5'd0 || not_pedaling !== 1'b1) begin
            errors++;
            $display("FAIL clean_idle: got cad=%0d np=%b expected cad=0 np=1", cadence, not_pedaling);
        end
    endtask

    task automatic test_threshold();
        for (int n = 1; n <= 2; n++) begin
            for (int i = 0; i < n; i++) stroke(5, 6);
            to_window_end();
            checks++;
            if (cadence !== 5'(n) || not_pedaling !== ((n < 2) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL threshold_%0d: got cad=%0d np=%b expected cad=%0d np=%0d",
                         n, cadence, not_pedaling, n, (n < 2) ? 1 : 0);
            end
        end
    endtask

    task automatic test_saturation();
        // 32 minimum-period strokes fill one window exactly.
        for (int i = 0; i < 32; i++) stroke(4, 4);
        checks++;
        if (cadence !== 5'd31 || not_pedaling !== 1'b0) begin
            errors++;
            $display("FAIL saturation: got cad=%0d np=%b expected cad=31 np=0", cadence, not_pedaling);
        end
        stroke(4, 4);
        stroke(4, 4);
        idle((WIN - 1 - 2 - FILT) - (cyc % WIN));
        stroke(4, 4);
        checks++;
        if (cadence !== 5'd3 || cadence !== 5'(m_cad)) begin
            errors++;
            $display("FAIL stroke_on_tc: got cad=%0d expected 3", cadence);
        end
        to_window_end();
        checks++;
        if (cadence !== 5'd0 || not_pedaling !== 1'b1) begin
            errors++;
            $display("FAIL after_tc_window: got cad=%0d np=%b expected cad=0 np=1",
                     cadence, not_pedaling);
        end
    endtask

    task automatic test_averaging();
        int prev;
        int n;
        load_torque(12'h800);
        stroke(4, 4);
        checks++;
        if (avg_torque !== 12'h040) begin
            errors++; $display("FAIL avg_first: got %h expected 040", avg_torque);
        end
        n = 0;
        while (m_acc / 32 != 12'h800 && n < 400) begin
            prev = m_acc / 32;
            stroke(4, 4);
            n++;
            checks++;
            if (avg_torque !== 12'(m_acc / 32) || int'(avg_torque) < prev) begin
                errors++;
                $display("FAIL avg_converge[%0d]: got %h expected %h (prev %h)",
                         n, avg_torque, 12'(m_acc / 32), 12'(prev));
            end
        end
        checks++;
        if (avg_torque !== 12'h800) begin
            errors++; $display("FAIL avg_reach: got %h expected 800 after %0d strokes", avg_torque, n);
        end
        for (int i = 0; i < 3; i++) stroke(4, 4);
        checks++;
        if (avg_torque !== 12'h800) begin
            errors++; $display("FAIL avg_hold: got %h expected 800", avg_torque);
        end
        // New sample arrives on the stroke cycle itself.
        stroke(4, 4, 2 + FILT, 0);
        checks++;
        if (avg_torque !== 12'h800) begin
            errors++; $display("FAIL avg_coincident: got %h expected 800", avg_torque);
        end
        stroke(4, 4);
        checks++;
        if (avg_torque !== 12'h7C0) begin
            errors++; $display("FAIL avg_after_zero: got %h expected 7c0", avg_torque);
        end
    endtask

    task automatic test_reset_mid();
        to_window_end();
        load_torque(12'h300);
        for (int i = 0; i < 7; i++) stroke(4, 4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (avg_torque !== 12'h000 || cadence !== 5'd0 || not_pedaling !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid: got avg=%h cad=%0d np=%b expected 000/0/1",
                     avg_torque, cadence, not_pedaling);
        end
        for (int i = 0; i < 3; i++) stroke(4, 4);
        idle(WIN - 1 - cyc);
        checks++;
        if (cadence !== 5'd0) begin
            errors++; $display("FAIL reset_mid_pre_tc: got cad=%0d expected 0", cadence);
        end
        tick();
        checks++;
        if (cadence !== 5'd3 || not_pedaling !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_tc: got cad=%0d np=%b expected cad=3 np=0", cadence, not_pedaling);
        end
    endtask

    task automatic test_random();
        int n, hi, off;
        for (int w = 0; w < 4; w++) begin
            n = $urandom_range(0, 24);
            for (int i = 0; i < n; i++) begin
                hi  = $urandom_range(FILT, FILT + 2);
                off = $urandom_range(0, 11);
                stroke(hi, FILT, off, $urandom_range(0, 4095));
                checks++;
                if (avg_torque !== 12'(m_acc / 32)) begin
                    errors++;
                    $display("FAIL rand_avg[w%0d s%0d]: got %h expected %h",
                             w, i, avg_torque, 12'(m_acc / 32));
                end
            end
            to_window_end();
            checks++;
            if (cadence !== 5'(m_cad) || not_pedaling !== 1'(m_notped)) begin
                errors++;
                $display("FAIL rand_window[%0d]: got cad=%0d np=%b expected cad=%0d np=%0d",
                         w, cadence, not_pedaling, m_cad, m_notped);
            end
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_clean();
        test_threshold();
        test_saturation();
        test_averaging();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
